// File: rtl/spi_tx_serializer.sv
// SPI transmit serializer: accepts a D_PACK-bit word over valid/ready and shifts it out with an internally
// generated SCLK in all four CPOL/CPHA modes. Define SPI_TX_CS_EN to add a registered active-low CS_N output.
module spi_tx_serializer #(
    parameter int unsigned D_PACK  = 8,
    parameter int unsigned CLK_DIV = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [D_PACK-1:0] DATA_IN,
    input  logic              LOAD_VALID,
    output logic              LOAD_READY,
    input  logic              CPOL,
    input  logic              CPHA,
    input  logic              LSB_FIRST,
    output logic              SCLK,
    output logic              SER_OUT,
    output logic              BUSY,
    output logic              DONE
`ifdef SPI_TX_CS_EN
    ,
    output logic              CS_N
`endif
);

    localparam int unsigned       DIV_W     = $clog2(CLK_DIV + 1);
    localparam int unsigned       EDGE_W    = $clog2(2 * D_PACK + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * D_PACK);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_q;
    logic [D_PACK-1:0] shreg_q;
    logic [DIV_W-1:0]  div_q;
    logic [EDGE_W-1:0] edge_q;
    logic              cpha_q;
    logic              lsb_q;
    logic              sclk_q;
    logic              ser_q;
    logic              busy_q;
    logic              done_q;
    logic              ready_q;
`ifdef SPI_TX_CS_EN
    logic              cs_n_q;
    // Holding READY low in DONE guarantees at least one CS_N-high cycle between frames.
    localparam logic   READY_IN_DONE = 1'b0;
`else
    localparam logic   READY_IN_DONE = 1'b1;
`endif

    logic              accept_s;
    logic              div_wrap_s;
    logic              data_edge_s;
    logic [EDGE_W-1:0] edge_d;

    function automatic logic head_bit(input logic [D_PACK-1:0] word, input logic lsb_first);
        head_bit = lsb_first ? word[0] : word[D_PACK-1];
    endfunction

    function automatic logic [D_PACK-1:0] drop_head(input logic [D_PACK-1:0] word, input logic lsb_first);
        drop_head = lsb_first ? (word >> 1) : (word << 1);
    endfunction

    // Handshake, divider wrap, and which SCLK edges also advance SER_OUT.
    always_comb begin
        accept_s   = LOAD_VALID & ready_q;
        div_wrap_s = (div_q == DIV_LAST);
        edge_d     = edge_q + EDGE_W'(1'b1);
        if (cpha_q) begin
            data_edge_s = edge_d[0];
        end else begin
            data_edge_s = ~edge_d[0] & (edge_d != EDGE_LAST);
        end
    end

    // Frame FSM with all outputs registered.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            div_q   <= '0;
            edge_q  <= '0;
            cpha_q  <= 1'b0;
            lsb_q   <= 1'b0;
            sclk_q  <= 1'b0;
            ser_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
`ifdef SPI_TX_CS_EN
            cs_n_q  <= 1'b1;
`endif
        end else begin
            done_q <= 1'b0;
            if (accept_s) begin
                state_q <= ST_SHIFT;
                div_q   <= '0;
                edge_q  <= '0;
                cpha_q  <= CPHA;
                lsb_q   <= LSB_FIRST;
                sclk_q  <= CPOL;
                busy_q  <= 1'b1;
                ready_q <= 1'b0;
`ifdef SPI_TX_CS_EN
                cs_n_q  <= 1'b0;
`endif
                // CPHA=0 presents the first bit before any SCLK edge.
                if (!CPHA) begin
                    ser_q   <= head_bit(DATA_IN, LSB_FIRST);
                    shreg_q <= drop_head(DATA_IN, LSB_FIRST);
                end else begin
                    shreg_q <= DATA_IN;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        sclk_q <= CPOL;
                    end
                    ST_SHIFT: begin
                        if (edge_q == EDGE_LAST) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            ready_q <= READY_IN_DONE;
`ifdef SPI_TX_CS_EN
                            cs_n_q  <= 1'b1;
`endif
                        end else if (div_wrap_s) begin
                            div_q  <= '0;
                            edge_q <= edge_d;
                            sclk_q <= ~sclk_q;
                            if (data_edge_s) begin
                                ser_q   <= head_bit(shreg_q, lsb_q);
                                shreg_q <= drop_head(shreg_q, lsb_q);
                            end
                        end else begin
                            div_q <= div_q + DIV_W'(1'b1);
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
`ifdef SPI_TX_CS_EN
                        cs_n_q  <= 1'b1;
`endif
                    end
                endcase
            end
        end
    end

    assign LOAD_READY = ready_q;
    assign SCLK       = sclk_q;
    assign SER_OUT    = ser_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;
`ifdef SPI_TX_CS_EN
    assign CS_N       = cs_n_q;
`endif

endmodule

// File: tb/tb_spi_tx_serializer.sv
// Bench for spi_tx_serializer: two instances (8-bit/div 2 and 16-bit/div 1) checked every cycle against
// a frame-timing reference model, plus directed mode, back-to-back and reset scenarios.
`timescale 1ns/1ps
module tb_spi_tx_serializer;

    localparam int D0 = 8;
    localparam int V0 = 2;
    localparam int D1 = 16;
    localparam int V1 = 1;
`ifdef SPI_TX_CS_EN
    localparam int CS_EXTRA = 1;
`else
    localparam int CS_EXTRA = 0;
`endif

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic [1:0][15:0] din;
    logic [1:0]       valid, cpol, cpha, lsb;
    logic [1:0]       sclk, ser, busy, done, ready;
`ifdef SPI_TX_CS_EN
    logic [1:0]       csn;
`endif

    always #5 clk = ~clk;

    spi_tx_serializer #(.D_PACK(D0), .CLK_DIV(V0)) u_dut0 (
        .CLK(clk), .RST_N(rst_n), .DATA_IN(din[0][7:0]), .LOAD_VALID(valid[0]), .LOAD_READY(ready[0]),
        .CPOL(cpol[0]), .CPHA(cpha[0]), .LSB_FIRST(lsb[0]), .SCLK(sclk[0]), .SER_OUT(ser[0]),
        .BUSY(busy[0]), .DONE(done[0])
`ifdef SPI_TX_CS_EN
        , .CS_N(csn[0])
`endif
    );

    spi_tx_serializer #(.D_PACK(D1), .CLK_DIV(V1)) u_dut1 (
        .CLK(clk), .RST_N(rst_n), .DATA_IN(din[1]), .LOAD_VALID(valid[1]), .LOAD_READY(ready[1]),
        .CPOL(cpol[1]), .CPHA(cpha[1]), .LSB_FIRST(lsb[1]), .SCLK(sclk[1]), .SER_OUT(ser[1]),
        .BUSY(busy[1]), .DONE(done[1])
`ifdef SPI_TX_CS_EN
        , .CS_N(csn[1])
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Reference model: last accepted frame per instance, expressed as start cycle plus latched settings.
    int          cyc = 0;
    bit          started [2];
    int          t0 [2];
    logic [15:0] m_data [2];
    logic        m_cpol [2];
    logic        m_cpha [2];
    logic        m_lsb [2];
    logic        ser_before [2];
    logic        idle_sclk [2];

    function automatic int dpk(input int u);
        return (u == 0) ? D0 : D1;
    endfunction

    function automatic int divk(input int u);
        return (u == 0) ? V0 : V1;
    endfunction

    function automatic int frame_len(input int u);
        return 2 * dpk(u) * divk(u);
    endfunction

    // 0: idle, 1: frame in progress, 2: DONE cycle
    function automatic int phase(input int u, input int n);
        int t;
        if (!started[u]) return 0;
        t = n - t0[u];
        if (t >= 1 && t <= 1 + frame_len(u)) return 1;
        if (t == 2 + frame_len(u)) return 2;
        return 0;
    endfunction

    function automatic logic tx_bit(input int u, input int i);
        return m_lsb[u] ? m_data[u][i] : m_data[u][dpk(u) - 1 - i];
    endfunction

    function automatic logic exp_ser(input int u, input int n);
        int t, k, i;
        if (!started[u]) return 1'b0;
        t = n - t0[u];
        if (t > 1 + frame_len(u)) return tx_bit(u, dpk(u) - 1);
        k = (t - 1) / divk(u);
        if (!m_cpha[u]) begin
            i = k / 2;
        end else begin
            if (k == 0) return ser_before[u];
            i = (k - 1) / 2;
        end
        if (i > dpk(u) - 1) i = dpk(u) - 1;
        return tx_bit(u, i);
    endfunction

    function automatic logic exp_sclk(input int u, input int n);
        int k;
        if (phase(u, n) == 1) begin
            k = (n - t0[u] - 1) / divk(u);
            return m_cpol[u] ^ k[0];
        end
        if (phase(u, n) == 2) return m_cpol[u];
        return idle_sclk[u];
    endfunction

    function automatic logic exp_ready(input int u, input int n);
        if (phase(u, n) == 0) return 1'b1;
        if (phase(u, n) == 2) return (CS_EXTRA == 0);
        return 1'b0;
    endfunction

    function automatic logic exp_busy(input int u, input int n);
        return phase(u, n) == 1;
    endfunction

    function automatic logic exp_done(input int u, input int n);
        return phase(u, n) == 2;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int u = 0; u < 2; u++) begin
                started[u]   <= 1'b0;
                idle_sclk[u] <= 1'b0;
            end
        end else begin
            for (int u = 0; u < 2; u++) begin
                idle_sclk[u] <= (phase(u, cyc) == 2) ? m_cpol[u] : cpol[u];
                if (valid[u] && exp_ready(u, cyc)) begin
                    ser_before[u] <= exp_ser(u, cyc);
                    started[u]    <= 1'b1;
                    t0[u]         <= cyc;
                    m_data[u]     <= din[u];
                    m_cpol[u]     <= cpol[u];
                    m_cpha[u]     <= cpha[u];
                    m_lsb[u]      <= lsb[u];
                end
            end
            cyc <= cyc + 1;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            check($sformatf("u%0d busy", u),  32'(busy[u]),  32'(exp_busy(u, cyc)));
            check($sformatf("u%0d done", u),  32'(done[u]),  32'(exp_done(u, cyc)));
            check($sformatf("u%0d ready", u), 32'(ready[u]), 32'(exp_ready(u, cyc)));
            check($sformatf("u%0d sclk", u),  32'(sclk[u]),  32'(exp_sclk(u, cyc)));
            check($sformatf("u%0d ser", u),   32'(ser[u]),   32'(exp_ser(u, cyc)));
`ifdef SPI_TX_CS_EN
            check($sformatf("u%0d cs_n", u),  32'(csn[u]),   32'(!exp_busy(u, cyc)));
`endif
        end
    end

    // Receiver-side capture on rising SCLK for instance 0, and DONE pulse timestamps.
    logic       sclk0_prev = 1'b0;
    logic [7:0] cap = 8'h00;
    int         ncap = 0;
    int         last_done [2];
    int         prev_done [2];

    always @(negedge clk) begin
        sclk0_prev <= sclk[0];
        if (busy[0] && sclk[0] && !sclk0_prev) begin
            cap  <= {cap[6:0], ser[0]};
            ncap <= ncap + 1;
        end
        for (int u = 0; u < 2; u++) begin
            if (done[u]) begin
                last_done[u] <= cyc;
                prev_done[u] <= last_done[u];
            end
        end
    end

    initial begin
        int base;
        int first_t;
        int second_t;
        valid = '0;
        din   = '0;
        cpol  = '0;
        cpha  = '0;
        lsb   = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Mode 0 MSB-first 8'hA5 on u0; 16-bit word on u1 to check its frame length.
        din[0] = 16'h00A5; cpol[0] = 1'b0; cpha[0] = 1'b0; lsb[0] = 1'b0; valid[0] = 1'b1;
        din[1] = 16'h1234; cpol[1] = 1'b0; cpha[1] = 1'b1; lsb[1] = 1'b1; valid[1] = 1'b1;
        base = ncap;
        @(negedge clk);
        valid = '0;
        repeat (40) @(negedge clk);
        check("a5 bits", 32'(cap), 32'h0000_00A5);
        check("a5 edges", 32'(ncap - base), 32'd8);
        check("a5 done lat", 32'(last_done[0] - t0[0]), 32'(2 + 2 * D0 * V0));
        check("u1 done lat", 32'(last_done[1] - t0[1]), 32'(2 + 2 * D1 * V1));

        // Mode 3 LSB-first 8'h3C with every input scrambled mid-frame.
        cpol[0] = 1'b1;
        @(negedge clk);
        din[0] = 16'h003C; cpha[0] = 1'b1; lsb[0] = 1'b1; valid[0] = 1'b1;
        base = ncap;
        @(negedge clk);
        valid[0] = 1'b0;
        for (int i = 0; i < 30; i++) begin
            din[0]  = 16'($urandom);
            cpol[0] = 1'($urandom);
            cpha[0] = 1'($urandom);
            lsb[0]  = 1'($urandom);
            @(negedge clk);
        end
        cpol[0] = 1'b1;
        repeat (10) @(negedge clk);
        check("m3 bits", 32'(cap), 32'h0000_003C);
        check("m3 edges", 32'(ncap - base), 32'd8);
        check("m3 idle sclk", 32'(sclk[0]), 32'd1);

        // Back-to-back FF then 00 with LOAD_VALID held.
        cpol[0] = 1'b0; cpha[0] = 1'b0; lsb[0] = 1'b0; din[0] = 16'h00FF; valid[0] = 1'b1;
        @(negedge clk);
        first_t = t0[0];
        din[0] = 16'h0000;
        for (int i = 0; i < 60 && t0[0] == first_t; i++) @(negedge clk);
        second_t = t0[0];
        valid[0] = 1'b0;
        repeat (40) @(negedge clk);
        check("b2b accept gap", 32'(second_t - first_t), 32'(2 + 2 * D0 * V0 + CS_EXTRA));
        check("b2b accept vs done", 32'(second_t - prev_done[0]), 32'(CS_EXTRA));
        check("b2b done gap", 32'(last_done[0] - prev_done[0]), 32'(2 + 2 * D0 * V0 + CS_EXTRA));

        // Asynchronous reset mid-frame, then CPOL=1 held through release.
        cpol = 2'b11; cpha[0] = 1'b0; din[0] = 16'h005A; valid[0] = 1'b1;
        @(negedge clk);
        valid[0] = 1'b0;
        repeat (10) @(negedge clk);
        check("rst precond busy", 32'(busy[0]), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst sclk", 32'(sclk[0]), 32'd0);
        check("rst busy", 32'(busy[0]), 32'd0);
        check("rst ready", 32'(ready[0]), 32'd1);
        check("rst done", 32'(done[0]), 32'd0);
        check("rst ser", 32'(ser[0]), 32'd0);
`ifdef SPI_TX_CS_EN
        check("rst cs_n", 32'(csn[0]), 32'd1);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel sclk u0", 32'(sclk[0]), 32'd1);
        check("rel sclk u1", 32'(sclk[1]), 32'd1);
        @(negedge clk);

        // Random traffic with inputs changing every cycle and one asynchronous reset.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (i == 700) begin
                #2 rst_n = 1'b0;
            end else begin
                rst_n = 1'b1;
            end
            for (int u = 0; u < 2; u++) begin
                din[u]   = 16'($urandom);
                valid[u] = ($urandom_range(0, 3) != 0);
                cpol[u]  = 1'($urandom);
                cpha[u]  = 1'($urandom);
                lsb[u]   = 1'($urandom);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        valid = '0;
        repeat (60) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
